// File: rtl/c2f_chunk_consumer.sv
// c2f_chunk_consumer: drains pending chunks from the C2F burst RAM, acks each, keeps a running checksum.
// Optional C2F_CONSUMER_PERF_EN adds an idleCycles counter of empty-ring IDLE cycles.
module c2f_chunk_consumer #(
    parameter int IDX_NBITS   = 3,
    parameter int OFF_NBITS   = 4,
    parameter int DATA_NBITS  = 64,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  sysClk,
    input  logic                  sysRst_n,
    input  logic [IDX_NBITS-1:0]  wrIndex,
    output logic [IDX_NBITS-1:0]  rdIndex,
    output logic [OFF_NBITS-1:0]  rdOffset,
    input  logic [DATA_NBITS-1:0] rdData,
    output logic                  dtAck,
    output logic [DATA_NBITS-1:0] csData,
    output logic                  csValid,
    input  logic                  csReset,
    input  logic [31:0]           countInit
`ifdef C2F_CONSUMER_PERF_EN
    ,
    output logic [31:0]           idleCycles
`endif
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, ACK} state_e;
    state_e                  state_q, state_d;
    logic [IDX_NBITS-1:0]    idx_q, idx_d;
    logic [OFF_NBITS-1:0]    off_q, off_d;
    logic [RAM_LATENCY-1:0]  vpipe_q, vpipe_d, vpipe_shift;
    logic [DATA_NBITS-1:0]   sum_q, sum_d;
    logic [31:0]             cnt_q, cnt_d;
    logic                    cs_valid_q, cs_valid_d;
    logic                    load_q;
    logic                    issue, empty, acc;
    assign empty       = wrIndex == idx_q;
    assign vpipe_shift = vpipe_q << 1;
    assign vpipe_d     = vpipe_shift | RAM_LATENCY'(issue);
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        off_d   = off_q;
        issue   = 1'b0;
        dtAck   = 1'b0;
        case (state_q)
            IDLE:  state_d = empty ? IDLE : READ;
            READ: begin
                issue   = 1'b1;
                off_d   = off_q + 1'b1;
                state_d = &off_q ? DRAIN : READ;
            end
            // leave once the last issued read has reached the tap
            DRAIN: state_d = (vpipe_shift == '0) ? ACK : DRAIN;
            ACK: begin
                dtAck   = 1'b1;
                idx_d   = idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign acc = vpipe_q[RAM_LATENCY-1] && !cs_valid_q && cnt_q != 32'd0;
    always_comb begin
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        cs_valid_d = cs_valid_q;
        if (load_q || csReset) begin
            sum_d      = '0;
            cnt_d      = countInit;
            cs_valid_d = 1'b0;
        end else if (acc) begin
            sum_d      = sum_q + rdData;
            cnt_d      = cnt_q - 32'd1;
            cs_valid_d = cnt_q == 32'd1;
        end
    end
    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            off_q      <= '0;
            vpipe_q    <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            cs_valid_q <= 1'b0;
            load_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            off_q      <= off_d;
            vpipe_q    <= vpipe_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            cs_valid_q <= cs_valid_d;
            load_q     <= 1'b0;
        end
    end
    assign rdIndex  = idx_q;
    assign rdOffset = off_q;
    assign csData   = sum_q;
    assign csValid  = cs_valid_q;
`ifdef C2F_CONSUMER_PERF_EN
    logic [31:0] perf_q, perf_d;
    always_comb begin
        perf_d = perf_q;
        if (csReset)
            perf_d = '0;
        else if (state_q == IDLE && empty && !(&perf_q))
            perf_d = perf_q + 32'd1;
    end
    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n)
            perf_q <= '0;
        else
            perf_q <= perf_d;
    end
    assign idleCycles = perf_q;
`endif
endmodule
